// File: rtl/vend_if.sv
// Handshake bundle between a vending front panel and the vend_controller.
// The slave modport is the controller; the master modport drives coins and selections.
interface vend_if;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic [5:0] credit;
    logic       dispense;
    logic [1:0] dispense_id;
    logic       change_5;
    logic       coin_reject;
    logic       sel_fail;
    logic       busy;

    modport master (
        output coin, sel_valid, sel, cancel,
        input  credit, dispense, dispense_id, change_5, coin_reject, sel_fail, busy
    );

    modport slave (
        input  coin, sel_valid, sel, cancel,
        output credit, dispense, dispense_id, change_5, coin_reject, sel_fail, busy
    );
endinterface

// File: rtl/vend_controller.sv
// Four-product vending controller: accepts 5/10 coins up to MAX_CREDIT, vends on
// selection, refunds remaining credit one 5-unit pulse per cycle, and refunds
// automatically after TIMEOUT idle cycles. All outputs are registered.
module vend_controller #(
    parameter int PRICE0     = 15,
    parameter int PRICE1     = 20,
    parameter int PRICE2     = 25,
    parameter int PRICE3     = 30,
    parameter int MAX_CREDIT = 40,
    parameter int TIMEOUT    = 16
) (
    input  logic  clk,
    input  logic  rst,
    vend_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [6:0]       MAX_SUM   = 7'(MAX_CREDIT);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [5:0]       credit_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic             dispense_q;
    logic [1:0]       dispense_id_q;
    logic             change_5_q;
    logic             coin_reject_q;
    logic             sel_fail_q;
    logic             busy_q;

    logic [5:0]       coin_val_s;
    logic             coin_present_s;
    logic             coin_valid_s;
    logic [6:0]       coin_sum_s;
    logic             coin_fits_s;
    logic [5:0]       price_s;
    logic             activity_s;

    function automatic logic [5:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = 6'(PRICE0);
            2'd1:    price_of = 6'(PRICE1);
            2'd2:    price_of = 6'(PRICE2);
            default: price_of = 6'(PRICE3);
        endcase
    endfunction

    // Decode the coin, check whether it fits under the ceiling, look up the price.
    always_comb begin
        coin_val_s = 6'd0;
        case (bus.coin)
            2'b01:   coin_val_s = 6'd5;
            2'b10:   coin_val_s = 6'd10;
            default: coin_val_s = 6'd0;
        endcase
        coin_present_s = (bus.coin != 2'b00);
        coin_valid_s   = (bus.coin == 2'b01) || (bus.coin == 2'b10);
        coin_sum_s     = {1'b0, credit_q} + {1'b0, coin_val_s};
        coin_fits_s    = coin_valid_s && (coin_sum_s <= MAX_SUM);
        price_s        = price_of(bus.sel);
        activity_s     = coin_present_s || bus.sel_valid || bus.cancel;
    end

    // Controller state machine with all outputs registered; pulses default low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            credit_q      <= 6'd0;
            idle_cnt_q    <= '0;
            dispense_q    <= 1'b0;
            dispense_id_q <= 2'd0;
            change_5_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_fail_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            dispense_q    <= 1'b0;
            dispense_id_q <= 2'd0;
            change_5_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_fail_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    idle_cnt_q <= '0;
                    if (coin_fits_s) begin
                        credit_q <= coin_sum_s[5:0];
                        state_q  <= CREDIT;
                    end else begin
                        coin_reject_q <= coin_present_s;
                    end
                    busy_q <= 1'b0;
                end
                CREDIT: begin
                    if (bus.cancel) begin
                        // Cancel wins; a coin offered alongside is handed back.
                        coin_reject_q <= coin_present_s;
                        idle_cnt_q    <= '0;
                        state_q       <= CHANGE;
                        busy_q        <= 1'b1;
                    end else if (bus.sel_valid && (credit_q >= price_s)) begin
                        coin_reject_q <= coin_present_s;
                        credit_q      <= credit_q - price_s;
                        dispense_q    <= 1'b1;
                        dispense_id_q <= bus.sel;
                        idle_cnt_q    <= '0;
                        state_q       <= DISPENSE;
                        busy_q        <= 1'b1;
                    end else if (activity_s) begin
                        // Refused selection and/or coin: the coin is still judged on its own.
                        sel_fail_q <= bus.sel_valid;
                        idle_cnt_q <= '0;
                        if (coin_fits_s) begin
                            credit_q <= coin_sum_s[5:0];
                        end else begin
                            coin_reject_q <= coin_present_s;
                        end
                        busy_q <= 1'b0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        idle_cnt_q <= '0;
                        state_q    <= CHANGE;
                        busy_q     <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_ONE;
                        busy_q     <= 1'b0;
                    end
                end
                DISPENSE: begin
                    coin_reject_q <= coin_present_s;
                    if (credit_q != 6'd0) begin
                        state_q <= CHANGE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                CHANGE: begin
                    coin_reject_q <= coin_present_s;
                    if (credit_q == 6'd0) begin
                        // Defensive exit: never decrement below zero.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        credit_q   <= credit_q - 6'd5;
                        change_5_q <= 1'b1;
                        if (credit_q == 6'd5) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    credit_q <= 6'd0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.credit      = credit_q;
    assign bus.dispense    = dispense_q;
    assign bus.dispense_id = dispense_id_q;
    assign bus.change_5    = change_5_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sel_fail    = sel_fail_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios followed by random traffic,
// every cycle compared against a credit-ledger reference model.
module tb_vend_controller;
    localparam int MAXC = 40;
    localparam int TMO  = 16;

    localparam int M_IDLE   = 0;
    localparam int M_HOLD   = 1;
    localparam int M_VEND   = 2;
    localparam int M_REFUND = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_if bus();

    vend_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // reference ledger
    int m_mode, m_credit, m_idle;
    int e_disp, e_id, e_ch, e_rej, e_fail;

    function automatic int price(input int i);
        int p[4] = '{15, 20, 25, 30};
        return p[i];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_idle = 0;
        e_disp = 0; e_id = 0; e_ch = 0; e_rej = 0; e_fail = 0;
    endtask

    task automatic model(input int c, input int sv, input int s, input int cn);
        int  val;
        bit  fits;
        bit  present;
        val     = (c == 1) ? 5 : ((c == 2) ? 10 : 0);
        present = (c != 0);
        fits    = (val != 0) && (m_credit + val <= MAXC);
        e_disp = 0; e_id = 0; e_ch = 0; e_rej = 0; e_fail = 0;
        case (m_mode)
            M_IDLE: begin
                if (fits) begin m_credit += val; m_mode = M_HOLD; m_idle = 0; end
                else e_rej = present;
            end
            M_HOLD: begin
                if (cn != 0) begin
                    e_rej = present; m_mode = M_REFUND; m_idle = 0;
                end else if (sv != 0 && m_credit >= price(s)) begin
                    e_rej = present; m_credit -= price(s);
                    e_disp = 1; e_id = s; m_mode = M_VEND; m_idle = 0;
                end else if (sv != 0 || present) begin
                    e_fail = sv; m_idle = 0;
                    if (fits) m_credit += val; else e_rej = present;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin m_mode = M_REFUND; m_idle = 0; end
                end
            end
            M_VEND: begin
                e_rej = present;
                m_mode = (m_credit > 0) ? M_REFUND : M_IDLE;
            end
            default: begin
                e_rej = present; m_credit -= 5; e_ch = 1;
                if (m_credit == 0) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".credit"},   32'(bus.credit),      32'(m_credit));
        check({tag, ".dispense"}, 32'(bus.dispense),    32'(e_disp));
        check({tag, ".disp_id"},  32'(bus.dispense_id), 32'(e_id));
        check({tag, ".change5"},  32'(bus.change_5),    32'(e_ch));
        check({tag, ".coin_rej"}, 32'(bus.coin_reject), 32'(e_rej));
        check({tag, ".sel_fail"}, 32'(bus.sel_fail),    32'(e_fail));
        check({tag, ".busy"},     32'(bus.busy),
              32'((m_mode == M_VEND || m_mode == M_REFUND) ? 1 : 0));
    endtask

    task automatic step(input string tag, input int c, input int sv, input int s, input int cn);
        bus.coin = 2'(c); bus.sel_valid = 1'(sv); bus.sel = 2'(s); bus.cancel = 1'(cn);
        @(posedge clk);
        model(c, sv, s, cn);
        #1;
        check_all(tag);
        bus.coin = 2'd0; bus.sel_valid = 1'b0; bus.sel = 2'd0; bus.cancel = 1'b0;
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0);
    endtask

    initial begin
        int r, c, sv, cn;
        bus.coin = 2'd0; bus.sel_valid = 1'b0; bus.sel = 2'd0; bus.cancel = 1'b0;
        rst = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // coin 10,10 then product 1 at exactly the credit
        step("r036.c1", 2, 0, 0, 0);
        check("r036.credit10", 32'(bus.credit), 32'd10);
        step("r036.c2", 2, 0, 0, 0);
        step("r036.sel", 0, 1, 1, 0);
        check("r036.dispense", 32'(bus.dispense), 32'd1);
        check("r036.id", 32'(bus.dispense_id), 32'd1);
        check("r036.credit0", 32'(bus.credit), 32'd0);
        idle_steps("r036.tail", 2);

        // 25 credit, product 0, two change pulses
        step("r037.c1", 2, 0, 0, 0);
        step("r037.c2", 2, 0, 0, 0);
        step("r037.c3", 1, 0, 0, 0);
        step("r037.sel", 0, 1, 0, 0);
        check("r037.credit10", 32'(bus.credit), 32'd10);
        step("r037.disp", 0, 0, 0, 0);
        step("r037.ch1", 0, 0, 0, 0);
        check("r037.ch1pulse", 32'(bus.change_5), 32'd1);
        step("r037.ch2", 0, 0, 0, 0);
        check("r037.credit0", 32'(bus.credit), 32'd0);
        idle_steps("r037.tail", 2);

        // ceiling overflow and invalid coin, including during refund
        step("r038.c1", 2, 0, 0, 0);
        step("r038.c2", 2, 0, 0, 0);
        step("r038.c3", 2, 0, 0, 0);
        step("r038.c4", 1, 0, 0, 0);
        step("r038.over", 2, 0, 0, 0);
        check("r038.reject", 32'(bus.coin_reject), 32'd1);
        check("r038.credit35", 32'(bus.credit), 32'd35);
        step("r038.bad", 3, 0, 0, 0);
        step("r038.cancel", 0, 0, 0, 1);
        step("r038.badchg", 3, 0, 0, 0);
        step("r038.coinchg", 1, 0, 0, 0);
        idle_steps("r038.drain", 7);
        step("r038.badidle", 3, 0, 0, 0);
        check("r038.rejidle", 32'(bus.coin_reject), 32'd1);

        // refused selection, then cancel with a coin
        step("r039.c1", 2, 0, 0, 0);
        step("r039.c2", 1, 0, 0, 0);
        step("r039.sel", 0, 1, 3, 0);
        check("r039.selfail", 32'(bus.sel_fail), 32'd1);
        check("r039.credit15", 32'(bus.credit), 32'd15);
        step("r039.cancel", 1, 0, 0, 1);
        check("r039.reject", 32'(bus.coin_reject), 32'd1);
        idle_steps("r039.drain", 4);

        // inactivity refund
        step("r040.c1", 2, 0, 0, 0);
        idle_steps("r040.wait", TMO);
        check("r040.busy", 32'(bus.busy), 32'd1);
        step("r040.ch1", 0, 0, 0, 0);
        check("r040.busych", 32'(bus.busy), 32'd1);
        step("r040.ch2", 0, 0, 0, 0);
        idle_steps("r040.tail", 2);

        // asynchronous reset in the middle of a refund
        step("r041.c1", 2, 0, 0, 0);
        step("r041.c2", 2, 0, 0, 0);
        step("r041.cancel", 0, 0, 0, 1);
        step("r041.ch1", 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("r041.async");
        check("r041.credit0", 32'(bus.credit), 32'd0);
        @(posedge clk); #1;
        check_all("r041.held");
        rst = 1'b1;
        idle_steps("r041.after", 4);

        // random traffic with occasional quiet stretches to reach the timeout
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 249) begin
                idle_steps("rnd.quiet", 20);
            end else begin
                r  = int'($urandom_range(0, 99));
                c  = (r < 55) ? 0 : ((r < 75) ? 1 : ((r < 92) ? 2 : 3));
                sv = ($urandom_range(0, 5) == 0) ? 1 : 0;
                cn = ($urandom_range(0, 15) == 0) ? 1 : 0;
                step("rnd", c, sv, int'($urandom_range(0, 3)), cn);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE0, default 15, price of product 0 in credit units; multiple of 5, range 5..MAX_CREDIT.
REQ-002 Parameter PRICE1, default 20, price of product 1; same constraints as PRICE0.
REQ-003 Parameter PRICE2, default 25, price of product 2; same constraints as PRICE0.
REQ-004 Parameter PRICE3, default 30, price of product 3; same constraints as PRICE0.
REQ-005 Parameter MAX_CREDIT, default 40, maximum credit held; multiple of 5, at most 60.
REQ-006 Parameter TIMEOUT, default 16, idle cycles in CREDIT before an automatic refund; at least 2.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 coin  input  2  coin this cycle: 00 none, 01 five, 10 ten, 11 invalid.
REQ-010 sel_valid  input  1  product selection strobe, one cycle.
REQ-011 sel  input  2  product index, qualified by sel_valid.
REQ-012 cancel  input  1  refund request.
REQ-013 credit  output  6  current credit, registered.
REQ-014 dispense  output  1  one-cycle vend pulse.
REQ-015 dispense_id  output  2  product vended, valid while dispense=1.
REQ-016 change_5  output  1  one pulse per 5 units returned.
REQ-017 coin_reject  output  1  one-cycle pulse: the coin of the previous cycle was returned unaccepted.
REQ-018 sel_fail  output  1  one-cycle pulse: the selection of the previous cycle was refused for insufficient credit.
REQ-019 busy  output  1  high in states DISPENSE and CHANGE.

Function
REQ-020 The block SHALL use four states: IDLE, CREDIT, DISPENSE and CHANGE. All outputs SHALL be registered; every pulse output defaults to 0 each cycle.
REQ-021 IDLE, valid coin whose value fits (credit+value <= MAX_CREDIT): credit += value at that edge; next state CREDIT.
REQ-022 CREDIT, valid coin whose value fits: credit += value; idle counter cleared.
REQ-023 Coin 11, a coin that would exceed MAX_CREDIT, or any coin in DISPENSE/CHANGE: coin_reject=1 next cycle; credit unchanged.
REQ-024 CREDIT, sel_valid with credit >= price(sel): same edge credit -= price, dispense=1, dispense_id=sel, state DISPENSE; latency 1 cycle.
REQ-025 CREDIT, sel_valid with credit < price(sel): sel_fail=1 next cycle; credit and state unchanged; idle counter cleared.
REQ-026 Priority in CREDIT: cancel > sel_valid > coin. A coin in the same cycle as an accepted cancel or selection SHALL be rejected per REQ-023.
REQ-027 CREDIT, cancel: state CHANGE. cancel and sel_valid SHALL be ignored in IDLE, DISPENSE and CHANGE.
REQ-028 CREDIT, TIMEOUT consecutive cycles without a coin, sel_valid or cancel: state CHANGE (refund).
REQ-029 DISPENSE lasts exactly one cycle: next state CHANGE if credit > 0, else IDLE.
REQ-030 CHANGE, each cycle: credit -= 5 and change_5=1 next cycle. On the edge where credit reaches 0, state becomes IDLE. Total change_5 pulses = entry credit / 5.
REQ-031 Credit SHALL always be a multiple of 5 and within 0..MAX_CREDIT. No arithmetic wrap is permitted.
REQ-032 busy SHALL equal (state == DISPENSE or state == CHANGE).

Reset
REQ-033 While rst=0, regardless of clk: state IDLE; credit, dispense, dispense_id, change_5, coin_reject, sel_fail, busy and the idle counter all 0.
REQ-034 Reset asserted mid-DISPENSE or mid-CHANGE SHALL abort the operation. Unreturned credit is discarded and no further pulses are issued.
REQ-035 After rst deasserts, the first rising edge SHALL apply normal IDLE behaviour.

Verification
REQ-036 coin 10,10 then sel=1 (price 20) -> credit 10,20; dispense=1, dispense_id=1 one cycle; credit 0; no change_5; return to IDLE.
REQ-037 coin 10,10,5 then sel=0 (price 15) -> dispense id 0, then exactly 2 change_5 pulses on consecutive cycles; credit 10->5->0; IDLE.
REQ-038 credit 35, coin 10 -> coin_reject=1, credit stays 35. coin 11 in any state -> coin_reject=1.
REQ-039 credit 15, sel=3 (price 30) -> sel_fail=1, credit 15, state CREDIT. Then cancel together with coin 5 -> coin_reject=1, 3 change_5 pulses.
REQ-040 credit 10, no activity for 16 cycles -> CHANGE entered, 2 change_5 pulses; busy high throughout CHANGE.
REQ-041 rst=0 asynchronously during CHANGE with credit 20 -> all outputs 0 immediately; no change_5 after release.
